// File: rtl/peak_detector_if.sv
// peak_detector_if: metric, sample and output AXI-stream handshakes of the peak detector
interface peak_detector_if #(parameter int MW = 40);
  logic [MW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [31:0]   i_tdata;
  logic          i_tlast;
  logic          i_tvalid;
  logic          i_tready;
  logic [31:0]   o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          o_tready;
  modport master (
    output m_tdata, m_tlast, m_tvalid, i_tdata, i_tlast, i_tvalid, o_tready,
    input  m_tready, i_tready, o_tdata, o_tlast, o_tvalid
  );
  modport slave (
    input  m_tdata, m_tlast, m_tvalid, i_tdata, i_tlast, i_tvalid, o_tready,
    output m_tready, i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/peak_detector.sv
// peak_detector: confirms a metric peak held for CP_SIZE beats, then emits PKT_SIZE delayed samples
module peak_detector #(
  parameter int CP_SIZE = 128,
  parameter int PKT_SIZE = 1152,
  localparam int MW = 32 + $clog2(CP_SIZE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [MW-1:0]     threshold,
  peak_detector_if.slave    bus,
  output logic              detect,
  output logic [MW-1:0]     peak_metric
);
  localparam int SW = CP_SIZE > 1 ? $clog2(CP_SIZE) : 1;
  localparam int CW = $clog2(PKT_SIZE + 1);
  typedef enum logic [1:0] {SEARCH, TRACK, OUTPUT} state_t;
  state_t state, state_n;
  logic [MW-1:0] max_q, max_n;
  logic [SW-1:0] since, since_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [31:0] dl [CP_SIZE];
  logic rdy, beat, emit, last, det, rst_any, unused_tlast;
  assign rst_any = reset | clear;
  assign rdy = !bus.o_tvalid || bus.o_tready;
  assign beat = bus.m_tvalid && bus.i_tvalid && rdy;
  assign bus.m_tready = rdy && bus.i_tvalid;
  assign bus.i_tready = rdy && bus.m_tvalid;
  assign unused_tlast = bus.m_tlast ^ bus.i_tlast;
  always_comb begin
    state_n = state;
    max_n = max_q;
    since_n = since;
    cnt_n = cnt;
    cnt_inc = cnt + 1'b1;
    emit = 1'b0;
    last = 1'b0;
    det = 1'b0;
    if (beat)
      case (state)
        SEARCH: if (bus.m_tdata >= threshold) begin
          state_n = TRACK;
          max_n = bus.m_tdata;
          since_n = '0;
        end
        TRACK: if (bus.m_tdata > max_q) begin
          max_n = bus.m_tdata;
          since_n = '0;
        end else if (since == SW'(CP_SIZE - 1)) begin
          det = 1'b1;
          emit = 1'b1;
          last = (PKT_SIZE == 1);
          state_n = last ? SEARCH : OUTPUT;
          cnt_n = last ? '0 : CW'(1);
          max_n = last ? '0 : max_q;
        end else begin
          since_n = since + 1'b1;
        end
        default: begin
          emit = 1'b1;
          last = (cnt_inc == CW'(PKT_SIZE));
          state_n = last ? SEARCH : OUTPUT;
          cnt_n = last ? '0 : cnt_inc;
          max_n = last ? '0 : max_q;
        end
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst_any) begin
      state <= SEARCH;
      max_q <= '0;
      since <= '0;
      cnt <= '0;
      dl <= '{default: '0};
      detect <= 1'b0;
      peak_metric <= '0;
      bus.o_tvalid <= 1'b0;
      bus.o_tlast <= 1'b0;
      bus.o_tdata <= '0;
    end else begin
      state <= state_n;
      max_q <= max_n;
      since <= since_n;
      cnt <= cnt_n;
      detect <= det;
      if (det) peak_metric <= max_q;
      if (beat) begin
        dl[0] <= bus.i_tdata;
        for (int i = 1; i < CP_SIZE; i++) dl[i] <= dl[i-1];
      end
      // the oldest entry, read before the shift, is the sample CP_SIZE beats back
      if (emit) begin
        bus.o_tvalid <= 1'b1;
        bus.o_tdata <= dl[CP_SIZE-1];
        bus.o_tlast <= last;
      end else if (bus.o_tready) begin
        bus.o_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_peak_detector.sv
// tb_peak_detector: directed scenarios for peak_detector with CP_SIZE=4, PKT_SIZE=6, threshold=10
module tb_peak_detector;
  localparam int CP = 4;
  localparam int PKT = 6;
  localparam int MW = 35;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic [MW-1:0] threshold = MW'(10);
  logic detect;
  logic [MW-1:0] peak_metric;
  int errors = 0;
  int checks = 0;
  int idx = 0;
  int det_cnt = 0;
  int det_at = -1;
  logic [32:0] out_q [$];
  peak_detector_if #(.MW(MW)) bus ();
  peak_detector #(.CP_SIZE(CP), .PKT_SIZE(PKT)) dut (
    .clk(clk), .reset(reset), .clear(clear), .threshold(threshold),
    .bus(bus.slave), .detect(detect), .peak_metric(peak_metric)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.o_tvalid && bus.o_tready) out_q.push_back({bus.o_tlast, bus.o_tdata});
    if (detect) begin
      det_cnt++;
      det_at = idx - 1;
    end
  end
  function automatic logic [MW-1:0] m31(input int b);
    return MW'(b == 2 ? 12 : b == 3 ? 20 : b == 4 ? 15 : b < 2 ? 0 : 5);
  endfunction
  task automatic clear_log();
    idx = 0;
    out_q.delete();
    det_cnt = 0;
    det_at = -1;
  endtask
  task automatic reset_dut();
    reset = 1'b1;
    bus.m_tvalid = 1'b1;
    bus.i_tvalid = 1'b1;
    bus.m_tlast = 1'b0;
    bus.i_tlast = 1'b0;
    bus.o_tready = 1'b1;
    bus.m_tdata = '0;
    bus.i_tdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
  endtask
  task automatic beat(input logic [MW-1:0] mv);
    int n = 0;
    bus.m_tdata = mv;
    bus.i_tdata = 32'(idx);
    #1;
    while (!bus.m_tready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.m_tready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: beat %0d m_tready=%b, required 1 within 50 cycles", idx, bus.m_tready);
    end
    @(posedge clk);
    #1;
    idx++;
  endtask
  task automatic idle(input int n);
    bus.m_tvalid = 1'b0;
    bus.i_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    bus.m_tvalid = 1'b1;
    bus.i_tvalid = 1'b1;
  endtask
  task automatic run_seq31(input bit do_reset, input string tag);
    logic [32:0] e;
    if (do_reset) reset_dut(); else clear_log();
    for (int b = 0; b < 20; b++) beat(m31(b));
    idle(3);
    checks++;
    if (det_cnt !== 1 || det_at !== 7) begin errors++; $display("FAIL %s_detect: count=%0d beat=%0d, required 1 at beat 7", tag, det_cnt, det_at); end
    checks++;
    if (peak_metric !== MW'(20)) begin errors++; $display("FAIL %s_peak_metric: got %0d, required 20", tag, peak_metric); end
    checks++;
    if (out_q.size() !== 6) begin errors++; $display("FAIL %s_out_count: got %0d, required 6", tag, out_q.size()); end
    for (int k = 0; k < 6 && k < out_q.size(); k++) begin
      e = {k == 5, 32'(3 + k)};
      checks++;
      if (out_q[k] !== e) begin errors++; $display("FAIL %s_out[%0d]: got last=%b data=%0d, required last=%b data=%0d", tag, k, out_q[k][32], out_q[k][31:0], e[32], e[31:0]); end
    end
  endtask
  task automatic test_reset();
    reset_dut();
    checks++;
    if (bus.o_tvalid !== 1'b0 || bus.o_tlast !== 1'b0 || bus.o_tdata !== 32'd0) begin errors++; $display("FAIL reset_output: valid=%b last=%b data=%0d, required 0 0 0", bus.o_tvalid, bus.o_tlast, bus.o_tdata); end
    checks++;
    if (detect !== 1'b0 || peak_metric !== '0) begin errors++; $display("FAIL reset_detect: detect=%b peak=%0d, required 0 0", detect, peak_metric); end
    checks++;
    if (bus.m_tready !== 1'b1 || bus.i_tready !== 1'b1) begin errors++; $display("FAIL reset_ready: m=%b i=%b, required 1 1", bus.m_tready, bus.i_tready); end
    bus.i_tvalid = 1'b0;
    #1;
    checks++;
    if (bus.m_tready !== 1'b0 || bus.i_tready !== 1'b1) begin errors++; $display("FAIL ready_pairing: m=%b i=%b, required 0 1", bus.m_tready, bus.i_tready); end
    bus.i_tvalid = 1'b1;
  endtask
  task automatic test_basic();
    run_seq31(1'b1, "basic");
  endtask
  task automatic test_tie();
    reset_dut();
    for (int b = 0; b < 12; b++) beat(MW'(b == 0 ? 12 : 20));
    idle(3);
    checks++;
    if (det_cnt !== 1 || det_at !== 5) begin errors++; $display("FAIL tie_detect: count=%0d beat=%0d, required 1 at beat 5", det_cnt, det_at); end
    checks++;
    if (peak_metric !== MW'(20)) begin errors++; $display("FAIL tie_peak_metric: got %0d, required 20", peak_metric); end
    checks++;
    if (out_q.size() !== 6 || out_q[0] !== {1'b0, 32'd1} || out_q[5] !== {1'b1, 32'd6}) begin errors++; $display("FAIL tie_output: size=%0d first=%0h, required 6 samples 1..6", out_q.size(), out_q.size() > 0 ? out_q[0] : 33'h0); end
  endtask
  task automatic test_rising();
    reset_dut();
    for (int b = 0; b < 20; b++) beat(MW'(b < 10 ? 12 + b : 0));
    idle(3);
    checks++;
    if (det_cnt !== 1 || det_at !== 13) begin errors++; $display("FAIL rising_detect: count=%0d beat=%0d, required 1 at beat 13", det_cnt, det_at); end
    checks++;
    if (peak_metric !== MW'(21)) begin errors++; $display("FAIL rising_peak_metric: got %0d, required 21", peak_metric); end
    checks++;
    if (out_q.size() !== 6 || out_q[0] !== {1'b0, 32'd9} || out_q[5] !== {1'b1, 32'd14}) begin errors++; $display("FAIL rising_output: size=%0d first=%0h, required 6 samples 9..14", out_q.size(), out_q.size() > 0 ? out_q[0] : 33'h0); end
  endtask
  task automatic test_equal_threshold();
    reset_dut();
    for (int b = 0; b < 12; b++) beat(MW'(b == 1 ? 10 : 0));
    idle(3);
    checks++;
    if (det_cnt !== 1 || det_at !== 5) begin errors++; $display("FAIL equal_detect: count=%0d beat=%0d, required 1 at beat 5", det_cnt, det_at); end
    checks++;
    if (peak_metric !== MW'(10)) begin errors++; $display("FAIL equal_peak_metric: got %0d, required 10", peak_metric); end
    checks++;
    if (out_q.size() !== 6 || out_q[0] !== {1'b0, 32'd1}) begin errors++; $display("FAIL equal_output: size=%0d, required 6 starting at sample 1", out_q.size()); end
  endtask
  task automatic test_backpressure();
    reset_dut();
    for (int b = 0; b < 9; b++) beat(m31(b));
    bus.o_tready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.m_tready !== 1'b0 || bus.i_tready !== 1'b0) begin errors++; $display("FAIL stall_ready: m=%b i=%b, required 0 0", bus.m_tready, bus.i_tready); end
      checks++;
      if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== 32'd4) begin errors++; $display("FAIL stall_hold: valid=%b data=%0d, required 1 4", bus.o_tvalid, bus.o_tdata); end
    end
    bus.o_tready = 1'b1;
    for (int b = 9; b < 20; b++) beat(m31(b));
    idle(3);
    checks++;
    if (out_q.size() !== 6) begin errors++; $display("FAIL stall_out_count: got %0d, required 6", out_q.size()); end
    for (int k = 0; k < 6 && k < out_q.size(); k++) begin
      checks++;
      if (out_q[k] !== {k == 5, 32'(3 + k)}) begin errors++; $display("FAIL stall_out[%0d]: got %0h, required data %0d", k, out_q[k], 3 + k); end
    end
  endtask
  task automatic test_below_threshold();
    reset_dut();
    for (int b = 0; b < 1000; b++) beat(MW'(9));
    idle(3);
    checks++;
    if (det_cnt !== 0 || out_q.size() !== 0) begin errors++; $display("FAIL below_threshold: detects=%0d outputs=%0d, required 0 0", det_cnt, out_q.size()); end
  endtask
  task automatic test_clear_mid_frame();
    reset_dut();
    for (int b = 0; b < 10; b++) beat(m31(b));
    checks++;
    if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== 32'd5) begin errors++; $display("FAIL pre_clear: valid=%b data=%0d, required 1 5", bus.o_tvalid, bus.o_tdata); end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++;
    if (bus.o_tvalid !== 1'b0 || peak_metric !== '0 || detect !== 1'b0) begin errors++; $display("FAIL clear_abandon: valid=%b peak=%0d detect=%b, required 0 0 0", bus.o_tvalid, peak_metric, detect); end
    run_seq31(1'b0, "rerun");
  endtask
  initial begin
    bus.o_tready = 1'b1;
    test_reset();
    test_basic();
    test_tie();
    test_rising();
    test_equal_threshold();
    test_backpressure();
    test_below_threshold();
    test_clear_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/peak_detector.md
PEAK_DETECTOR -- requirements
Module: peak_detector

Interface
REQ-001 Parameter CP_SIZE, default 128: peak-confirmation window and internal sample delay, in samples.
REQ-002 Parameter PKT_SIZE, default 1152: number of samples emitted per detection.
REQ-003 Derived width MW = 32 + clog2(CP_SIZE+1), default 40.
REQ-004 Port clk, input, 1: the single clock.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port clear, input, 1: synchronous soft clear with the same effect as reset.
REQ-007 Port threshold, input, MW: unsigned detection threshold, sampled every beat.
REQ-008 Port m_tdata, input, MW: unsigned Schmidl-Cox metric stream.
REQ-009 Ports m_tlast, m_tvalid (input) and m_tready (output), 1 each: metric handshake; m_tlast is ignored.
REQ-010 Port i_tdata, input, 32: synchronised sample stream, sample-aligned with the metric stream.
REQ-011 Ports i_tlast, i_tvalid (input) and i_tready (output), 1 each: sample handshake; i_tlast is ignored.
REQ-012 Ports o_tdata (32), o_tlast, o_tvalid (outputs) and o_tready (input): detected-frame sample output.
REQ-013 Port detect, output, 1: one-cycle pulse on each confirmed peak.
REQ-014 Port peak_metric, output, MW: metric value of the last confirmed peak.

Function
REQ-015 A joint beat occurs when m_tvalid && i_tvalid && rdy, with rdy = !o_tvalid || o_tready.
- m_tready = rdy && i_tvalid; i_tready = rdy && m_tvalid.
- A valid stream is never consumed alone.
REQ-016 Delay line: a CP_SIZE-deep sample delay (RAM or shift register), advanced once per joint beat.
- The delayed sample at beat j is i_tdata of beat j-CP_SIZE.
- The line reads zero until it has filled.
REQ-017 The FSM has three states: SEARCH, TRACK and OUTPUT; it evaluates only on joint beats.
REQ-018 SEARCH -> TRACK when m_tdata >= threshold; on that beat max <= m_tdata and since <= 0.
REQ-019 TRACK, m_tdata > max (strictly): max <= m_tdata, since <= 0; ties keep the earlier peak.
REQ-020 TRACK, m_tdata <= max and since == CP_SIZE-1: confirm the peak.
- Assert detect for one cycle.
- peak_metric <= max.
- Emit the delayed sample (the peak sample) as output count 1.
- Go to OUTPUT with cnt = 1.
REQ-021 TRACK, any other beat: since <= since+1. Dropping below threshold does not abort TRACK.
REQ-022 OUTPUT: each joint beat emits the delayed sample and increments cnt.
- The beat with cnt == PKT_SIZE asserts o_tlast, then the FSM returns to SEARCH with max cleared.
- Metric comparisons are disabled while in OUTPUT.
REQ-023 Output is a registered single stage.
- o_tvalid, o_tdata and o_tlast load on an emitting beat.
- o_tvalid clears on o_tready when no new emission occurs.
- o_tdata stays stable while o_tvalid && !o_tready.
REQ-024 Latency: a confirmed peak sample appears on o_tdata one clock after the confirming beat.
- Its total delay from input is CP_SIZE beats + 1 clock.
REQ-025 In SEARCH and TRACK, delayed samples are discarded without emission.
REQ-026 Counters: since is clog2(CP_SIZE) bits; cnt is clog2(PKT_SIZE+1) bits; neither wraps.
REQ-027 Comparisons are unsigned and full MW width; no truncation.
REQ-028 PKT_SIZE == 1: the confirming beat both emits and asserts o_tlast, and the FSM returns to SEARCH.

Reset
REQ-029 On reset or clear:
- State = SEARCH; max, since and cnt = 0; peak_metric = 0.
- o_tvalid = 0, o_tlast = 0, o_tdata = 0, detect = 0.
- Delay line contents are zeroed.
REQ-030 Reset or clear in mid-OUTPUT abandons the frame immediately; the next o_tvalid requires a fresh detection.

Verification (bench uses CP_SIZE=4, PKT_SIZE=6, threshold=10, i_tdata = beat index)
REQ-031 Metric 0,0,12,20,15,5,5,5,5,... with o_tready=1:
- detect on beat 7.
- peak_metric = 20.
- o_tdata = 3,4,5,6,7,8, with o_tlast on 8.
REQ-032 Metric 12,20,20,20,20,... -> peak is beat 1 (tie kept); detect on beat 5; output starts at 1.
REQ-033 Metric 12,13,14,15,16,... rising for 10 beats, then 0 -> no detect until 4 beats after the maximum; output starts at the maximum's index.
REQ-034 o_tready low 3 cycles mid-frame -> m_tready and i_tready low; no sample lost or duplicated; o_tdata held stable.
REQ-035 Metric always 9 -> no detect and no o_tvalid over 1000 beats.
REQ-036 reset asserted at output count 3 -> o_tvalid=0 next cycle; a re-run of REQ-031 stimulus gives an identical result.
